// File: rtl/sdram_bist_pkg.sv
// rtl/sdram_bist_pkg.sv - FSM state codes, pattern modes and pattern constants for sdram_bist
package sdram_bist_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WFILL  = 3'd1;
  localparam logic [2:0] ST_WCMD   = 3'd2;
  localparam logic [2:0] ST_RCMD   = 3'd3;
  localparam logic [2:0] ST_RDRAIN = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [1:0] {
    MODE_ALT  = 2'd0,
    MODE_ADR  = 2'd1,
    MODE_WALK = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [7:0]  ALT_EVEN  = 8'hAA;
  localparam logic [7:0]  ALT_ODD   = 8'h55;

  // Galois right-shift form: feedback taps applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdram_bist_pattern.sv
// rtl/sdram_bist_pattern.sv - expected/write word generator, shared by the write and read phases
module sdram_bist_pattern
  import sdram_bist_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              restart_i,
  input  logic              step_i,
  input  logic [1:0]        mode_i,
  input  logic              index_odd_i,
  input  logic [DATA_W-1:0] adr_word_i,
  output logic [DATA_W-1:0] word_o
);

  localparam logic [DATA_W-1:0] WALK_INIT = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [15:0]       lfsr_q, lfsr_d;
  logic [DATA_W-1:0] walk_q, walk_d;
  logic [DATA_W-1:0] alt_word;
  logic [DATA_W-1:0] lfsr_word;

  // The walking one rotates with each word, which equals 1 << (index mod DATA_W)
  // without needing a divider for non-power-of-two widths.
  always_comb begin
    lfsr_d = lfsr_q;
    walk_d = walk_q;
    if (restart_i) begin
      lfsr_d = LFSR_SEED;
      walk_d = WALK_INIT;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
      walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
      walk_q <= WALK_INIT;
    end else begin
      lfsr_q <= lfsr_d;
      walk_q <= walk_d;
    end
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_rep
    assign alt_word[j]  = index_odd_i ? ALT_ODD[j % 8] : ALT_EVEN[j % 8];
    assign lfsr_word[j] = lfsr_q[j % 16];
  end

  always_comb begin
    word_o = '0;
    case (mode_e'(mode_i))
      MODE_ALT:  word_o = alt_word;
      MODE_ADR:  word_o = adr_word_i;
      MODE_WALK: word_o = walk_q;
      MODE_LFSR: word_o = lfsr_word;
      default:   word_o = '0;
    endcase
  end

endmodule

// File: rtl/sdram_bist.sv
// rtl/sdram_bist.sv - SDRAM BIST engine: write bursts, read back, compare; SDRAM_BIST_LOOP_EN enables auto-repeat
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADR_W      = 25,
  parameter int LEN_W      = 10,
  parameter int BURST_LEN  = 8,
  parameter int NUM_BURSTS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic [ADR_W-1:0]    start_adr_i,
  output logic                cmd_en_o,
  output logic                cmd_wr_rd_o,
  input  logic                cmd_av_i,
  output logic [LEN_W-1:0]    cmd_len_o,
  output logic [ADR_W-1:0]    cmd_adr_o,
  input  logic [LEN_W-1:0]    wr_remain_space_i,
  output logic                wr_en_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_mask_o,
  input  logic                rd_av_i,
  output logic                rd_en_o,
  input  logic [DATA_W-1:0]   rd_data_i,
`ifdef SDRAM_BIST_LOOP_EN
  output logic [15:0]         loop_cnt_o,
`endif
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_cnt_o,
  output logic [ADR_W-1:0]    first_err_adr_o
);

  localparam int              KW     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [LEN_W-1:0] BL     = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] LAST_W = LEN_W'(BURST_LEN - 1);
  localparam logic [ADR_W-1:0] BL_ADR = ADR_W'(BURST_LEN);
  localparam logic [KW-1:0]    LAST_K = KW'(NUM_BURSTS - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADR_W-1:0]  base_q, base_d;
  logic [ADR_W-1:0]  burst_adr_q, burst_adr_d;
  logic [ADR_W-1:0]  idx_q, idx_d;
  logic [ADR_W-1:0]  first_err_q, first_err_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [KW-1:0]     bcnt_q, bcnt_d;
  logic [15:0]       err_q, err_d;

  logic              accept;
  logic              fill_ok;
  logic              mismatch;
  logic              pat_restart;
  logic [ADR_W-1:0]  word_adr;
  logic [DATA_W-1:0] adr_word;
  logic [DATA_W-1:0] exp_word;

  assign accept   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // A burst is only begun with room for all of it, so it streams without gaps.
  assign fill_ok  = (wcnt_q != '0) || (wr_remain_space_i >= BL);
  assign word_adr = base_q + idx_q;

  assign wr_en_o     = (state_q == ST_WFILL) && fill_ok;
  assign rd_en_o     = (state_q == ST_RDRAIN) && rd_av_i;
  assign cmd_en_o    = ((state_q == ST_WCMD) || (state_q == ST_RCMD)) && cmd_av_i;
  assign cmd_wr_rd_o = (state_q == ST_RCMD);
  assign cmd_adr_o   = cmd_en_o ? burst_adr_q : '0;
  assign cmd_len_o   = BL;
  assign wr_data_o   = wr_en_o ? exp_word : '0;
  assign wr_mask_o   = '0;
  assign mismatch    = rd_en_o && (rd_data_i != exp_word);

  assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o          = (state_q == ST_DONE);
  assign pass_o          = done_o && (err_q == '0);
  assign err_cnt_o       = err_q;
  assign first_err_adr_o = first_err_q;

  for (genvar j = 0; j < DATA_W; j++) begin : g_adr
    if (j < ADR_W) begin : g_bit
      assign adr_word[j] = word_adr[j];
    end else begin : g_zero
      assign adr_word[j] = 1'b0;
    end
  end

  sdram_bist_pattern #(
    .DATA_W(DATA_W)
  ) u_pattern (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .restart_i  (pat_restart),
    .step_i     (wr_en_o || rd_en_o),
    .mode_i     (mode_q),
    .index_odd_i(idx_q[0]),
    .adr_word_i (adr_word),
    .word_o     (exp_word)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    burst_adr_d = burst_adr_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    bcnt_d      = bcnt_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    pat_restart = 1'b0;
    if (accept) begin
      state_d     = ST_WFILL;
      mode_d      = mode_i;
      base_d      = start_adr_i;
      burst_adr_d = start_adr_i;
      idx_d       = '0;
      wcnt_d      = '0;
      bcnt_d      = '0;
      err_d       = '0;
      first_err_d = '0;
      pat_restart = 1'b1;
    end else begin
      case (state_q)
        ST_WFILL: begin
          if (wr_en_o) begin
            idx_d = idx_q + ADR_W'(1);
            if (wcnt_q == LAST_W) begin
              wcnt_d  = '0;
              state_d = ST_WCMD;
            end else begin
              wcnt_d = wcnt_q + LEN_W'(1);
            end
          end
        end
        ST_WCMD: begin
          if (cmd_av_i) begin
            if (bcnt_q == LAST_K) begin
              // Read phase replays the same sequence from the first word.
              bcnt_d      = '0;
              burst_adr_d = base_q;
              idx_d       = '0;
              pat_restart = 1'b1;
              state_d     = ST_RCMD;
            end else begin
              bcnt_d      = bcnt_q + KW'(1);
              burst_adr_d = burst_adr_q + BL_ADR;
              state_d     = ST_WFILL;
            end
          end
        end
        ST_RCMD: begin
          if (cmd_av_i) begin
            burst_adr_d = burst_adr_q + BL_ADR;
            state_d     = ST_RDRAIN;
          end
        end
        ST_RDRAIN: begin
          if (rd_en_o) begin
            idx_d = idx_q + ADR_W'(1);
            if (mismatch) begin
              if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
              if (err_q == '0) first_err_d = word_adr;
            end
            if (wcnt_q == LAST_W) begin
              wcnt_d = '0;
              if (bcnt_q == LAST_K) begin
                bcnt_d  = '0;
                state_d = ST_DONE;
              end else begin
                bcnt_d  = bcnt_q + KW'(1);
                state_d = ST_RCMD;
              end
            end else begin
              wcnt_d = wcnt_q + LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
`ifdef SDRAM_BIST_LOOP_EN
          // Repeat with the captured mode/address; error state keeps accumulating.
          state_d     = ST_WFILL;
          burst_adr_d = base_q;
          idx_d       = '0;
          wcnt_d      = '0;
          bcnt_d      = '0;
          pat_restart = 1'b1;
`endif
        end
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      base_q      <= '0;
      burst_adr_q <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      err_q       <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      burst_adr_q <= burst_adr_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
    end
  end

`ifdef SDRAM_BIST_LOOP_EN
  logic [15:0] loop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loop_cnt_q <= '0;
    end else if (accept) begin
      loop_cnt_q <= '0;
    end else if ((state_q == ST_RDRAIN) && (state_d == ST_DONE) && (loop_cnt_q != 16'hFFFF)) begin
      loop_cnt_q <= loop_cnt_q + 16'd1;
    end
  end

  assign loop_cnt_o = loop_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_bist.sv
// tb/tb_sdram_bist.sv - randomized bench for sdram_bist with an ideal controller and pattern model
module tb_sdram_bist;

  localparam int DW = 16, AW = 25, LW = 10, BL = 8, NB = 4, DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_ni, start_i, cmd_av_i, rd_av_i;
  logic [1:0]    mode_i;
  logic [AW-1:0] start_adr_i, cmd_adr_o, first_err_adr_o;
  logic [LW-1:0] wr_remain_space_i, cmd_len_o;
  logic [DW-1:0] rd_data_i, wr_data_o;
  logic [DW/8-1:0] wr_mask_o;
  logic          cmd_en_o, cmd_wr_rd_o, wr_en_o, rd_en_o, busy_o, done_o, pass_o;
  logic [15:0]   err_cnt_o;

  always #5 clk = ~clk;

  sdram_bist dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i), .start_adr_i(start_adr_i),
    .cmd_en_o(cmd_en_o), .cmd_wr_rd_o(cmd_wr_rd_o), .cmd_av_i(cmd_av_i), .cmd_len_o(cmd_len_o),
    .cmd_adr_o(cmd_adr_o), .wr_remain_space_i(wr_remain_space_i), .wr_en_o(wr_en_o),
    .wr_data_o(wr_data_o), .wr_mask_o(wr_mask_o), .rd_av_i(rd_av_i), .rd_en_o(rd_en_o),
    .rd_data_i(rd_data_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .first_err_adr_o(first_err_adr_o)
  );

  int n_pass = 0, n_total = 0;

  // Controller/memory model and per-run expectations (owned by the ctrl process).
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] wq[$], rq[$], wr_log[$];
  logic [AW-1:0] cmd_log[$];
  int            run_mode, wr_idx, rd_idx, cmd_k, m_err;
  logic [AW-1:0] run_adr, m_first;
  bit            prev_fill_mid;

  // Knobs set by the main sequence.
  bit            corrupt_en, av_hold;
  logic [AW-1:0] corrupt_adr;
  int            space_cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] exp_word(input int m, input int i, input logic [AW-1:0] a);
    logic [15:0] l;
    l = 16'hACE1;
    case (m)
      0: return (i % 2 == 0) ? 16'hAAAA : 16'h5555;
      1: return a[DW-1:0];
      2: return 16'(1) << (i % DW);
      default: begin
        for (int s = 0; s < i; s++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        return l;
      end
    endcase
  endfunction

  initial begin : ctrl
    logic [DW-1:0] d;
    logic [AW-1:0] a, ea;
    int sp;
    cmd_av_i = 0; rd_av_i = 0; rd_data_i = '0; wr_remain_space_i = LW'(DEPTH);
    prev_fill_mid = 0; run_mode = 0; run_adr = '0;
    wr_idx = 0; rd_idx = 0; cmd_k = 0; m_err = 0; m_first = '0;
    forever begin
      @(posedge clk); #1;
      cmd_av_i  = !av_hold && ($urandom_range(0, 3) != 0);
      rd_av_i   = (rq.size() > 0) && ($urandom_range(0, 3) != 0);
      rd_data_i = (rq.size() > 0) ? rq[0] : '0;
      sp = DEPTH - wq.size();
      if (sp > space_cap) sp = space_cap;
      wr_remain_space_i = LW'(sp);
      @(negedge clk);
      if (!rst_ni) begin
        wq.delete(); rq.delete(); prev_fill_mid = 0;
      end else begin
        if (start_i && !busy_o) begin
          run_mode = int'(mode_i); run_adr = start_adr_i;
          wr_idx = 0; rd_idx = 0; cmd_k = 0; m_err = 0; m_first = '0;
          wr_log.delete(); cmd_log.delete(); mem.delete(); prev_fill_mid = 0;
        end
        if (cmd_en_o) begin
          chk("cmd_av", cmd_av_i, 1);
          ea = run_adr + AW'((cmd_k % NB) * BL);
          chk("cmd_adr", cmd_adr_o, ea);
          chk("cmd_wr_rd", cmd_wr_rd_o, (cmd_k >= NB) ? 1 : 0);
          chk("cmd_len", cmd_len_o, BL);
          cmd_log.push_back(cmd_adr_o);
          if (!cmd_wr_rd_o) begin
            chk("wq_full", wq.size(), BL);
            for (int i = 0; i < BL; i++)
              if (wq.size() > 0) mem[cmd_adr_o + AW'(i)] = wq.pop_front();
          end else begin
            for (int i = 0; i < BL; i++) begin
              a = cmd_adr_o + AW'(i);
              d = mem.exists(a) ? mem[a] : '0;
              if (corrupt_en && a == corrupt_adr) d = d ^ 16'h0010;
              rq.push_back(d);
            end
          end
          cmd_k++;
        end
        if (prev_fill_mid) chk("wr_no_gap", wr_en_o, 1);
        if (wr_en_o) begin
          if (wr_idx % BL == 0) chk("fill_space", (wr_remain_space_i >= LW'(BL)) ? 1 : 0, 1);
          chk("wr_data", wr_data_o, exp_word(run_mode, wr_idx, run_adr + AW'(wr_idx)));
          chk("wr_mask", wr_mask_o, 0);
          wq.push_back(wr_data_o);
          wr_log.push_back(wr_data_o);
          wr_idx++;
          chk("wq_bound", (wq.size() <= BL) ? 1 : 0, 1);
        end
        prev_fill_mid = wr_en_o && (wr_idx % BL != 0);
        if (rd_av_i || rd_en_o) begin
          chk("rd_en", rd_en_o, rd_av_i);
          if (rd_en_o && rq.size() > 0) begin
            d = rq.pop_front();
            if (d !== exp_word(run_mode, rd_idx, run_adr + AW'(rd_idx))) begin
              m_err++;
              if (m_err == 1) m_first = run_adr + AW'(rd_idx);
            end
            rd_idx++;
          end
        end
      end
    end
  end

  task automatic check_quiet(input string name);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_pass"}, pass_o, 0);
    chk({name, "_err"}, err_cnt_o, 0);
    chk({name, "_first"}, first_err_adr_o, 0);
    chk({name, "_cmd_en"}, cmd_en_o, 0);
    chk({name, "_cmd_adr"}, cmd_adr_o, 0);
    chk({name, "_wr_en"}, wr_en_o, 0);
    chk({name, "_wr_data"}, wr_data_o, 0);
    chk({name, "_rd_en"}, rd_en_o, 0);
  endtask

  task automatic start_run(input int m, input logic [AW-1:0] a);
    @(posedge clk); #1;
    mode_i = 2'(m); start_adr_i = a; start_i = 1;
    @(negedge clk);
    chk("busy_before_start", busy_o, 0);
    @(posedge clk); #1;
    start_i = 0;
    @(negedge clk);
    chk("busy_after_start", busy_o, 1);
    chk("done_cleared", done_o, 0);
    chk("err_cleared", err_cnt_o, 0);
    chk("first_cleared", first_err_adr_o, 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, done_o, 1);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_err_cnt"}, err_cnt_o, m_err);
    chk({name, "_first_err"}, first_err_adr_o, m_first);
    chk({name, "_pass"}, pass_o, (m_err == 0) ? 1 : 0);
    chk({name, "_cmds"}, cmd_k, 2 * NB);
    chk({name, "_rd_words"}, rd_idx, NB * BL);
  endtask

  initial begin : main
    logic [AW-1:0] a;
    int n;
    rst_ni = 0; start_i = 0; mode_i = '0; start_adr_i = '0;
    corrupt_en = 0; corrupt_adr = '0; av_hold = 0; space_cap = DEPTH;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst_ni = 1;

    start_run(1, 25'h100);
    wait_done("adr_mode");
    chk("adr_mode_ncmd", cmd_log.size(), 8);
    if (cmd_log.size() == 8)
      for (int k = 0; k < 8; k++) chk($sformatf("adr_mode_cmd%0d", k), cmd_log[k], 25'h100 + 8 * (k % 4));
    chk("adr_mode_pass_lit", pass_o, 1);
    chk("adr_mode_err_lit", err_cnt_o, 0);

    corrupt_en = 1; corrupt_adr = 25'h105;
    start_run(1, 25'h100);
    wait_done("corrupt");
    chk("corrupt_err_lit", err_cnt_o, 1);
    chk("corrupt_first_lit", first_err_adr_o, 25'h105);
    chk("corrupt_pass_lit", pass_o, 0);
    corrupt_en = 0;

    start_run(3, 25'h40);
    wait_done("lfsr");
    chk("lfsr_nwr", wr_log.size(), NB * BL);
    if (wr_log.size() >= 2) begin
      chk("lfsr_word0_lit", wr_log[0], 16'hACE1);
      chk("lfsr_word1_lit", wr_log[1], 16'hE270);
    end

    av_hold = 1;
    start_run(2, 25'h1234);
    n = 0;
    while (wr_idx < BL && n < 200) begin @(negedge clk); n++; end
    chk("hold_first_fill", wr_idx, BL);
    space_cap = 4;
    repeat (20) @(negedge clk);
    chk("hold_no_more_wr", wr_idx, BL);
    chk("hold_no_cmd", cmd_k, 0);
    chk("hold_busy", busy_o, 1);
    av_hold = 0; space_cap = DEPTH;
    wait_done("hold");

    start_run(1, 25'h2000);
    repeat (10) @(posedge clk);
    #1; mode_i = 2'd0; start_adr_i = 25'h0; start_i = 1;
    @(posedge clk); #1; start_i = 0;
    @(negedge clk);
    chk("start_ignored_busy", busy_o, 1);
    wait_done("start_busy");

    start_run(2, 25'h3000);
    n = 0;
    while (rd_idx < 3 && n < 2000) begin @(negedge clk); n++; end
    chk("reach_rdrain", (rd_idx >= 3) ? 1 : 0, 1);
    @(posedge clk); #1;
    rst_ni = 0;
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk); #1;
    rst_ni = 1;

    start_run(0, 25'h1FFFFFC);
    wait_done("wrap");
    if (cmd_log.size() >= 2) chk("wrap_cmd1_lit", cmd_log[1], 25'h0000004);
    else chk("wrap_ncmd", cmd_log.size(), 8);
    if (wr_log.size() >= 3) begin
      chk("wrap_w0_lit", wr_log[0], 16'hAAAA);
      chk("wrap_w1_lit", wr_log[1], 16'h5555);
      chk("wrap_w2_lit", wr_log[2], 16'hAAAA);
    end
    chk("wrap_pass_lit", pass_o, 1);

    for (int r = 0; r < 6; r++) begin
      a = AW'($urandom);
      corrupt_en = ($urandom_range(0, 1) == 1);
      corrupt_adr = a + AW'($urandom_range(0, NB * BL - 1));
      start_run($urandom_range(0, 3), a);
      wait_done($sformatf("rand%0d", r));
    end
    corrupt_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_bist.md
Name: sdram_bist

Overview:
Parametrised SDRAM built-in self-test engine. It drives the SDRAM controller user interface (command, write FIFO, read FIFO) in place of hand-coded test sequences. It writes NUM_BURSTS bursts of BURST_LEN words from START_ADR using a selectable data pattern, reads every burst back, compares each word, and reports pass/fail, error count and first failing address to the UART print logic in top.

Parameters:
DATA_W, 16, SDRAM data width in bits (8..32)
ADR_W, 25, controller word-address width
LEN_W, 10, controller cmd_len width
BURST_LEN, 8, words per command (1..2^LEN_W-1, must not exceed controller FIFO depth)
NUM_BURSTS, 4, bursts per run (>=1)

Ports:
clk  in  1  controller clock (133 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request, ignored while busy
mode  in  2  pattern select: 0 alt AAAA/5555, 1 address-as-data, 2 walking one, 3 LFSR
start_adr  in  ADR_W  first word address, sampled on accepted start
cmd_en  out  1  command strobe
cmd_wr_rd  out  1  0 write, 1 read
cmd_av  in  1  controller can accept a command
cmd_len  out  LEN_W  words in command, constant BURST_LEN
cmd_adr  out  ADR_W  burst start address
wr_remain_space  in  LEN_W  free words in write FIFO
wr_en  out  1  write FIFO push
wr_data  out  DATA_W  write word
wr_mask  out  DATA_W/8  byte mask, constant 0
rd_av  in  1  read FIFO non-empty
rd_en  out  1  read FIFO pop (FWFT: rd_data valid in the same cycle)
rd_data  in  DATA_W  read word
busy  out  1  run in progress
done  out  1  run finished, held until next accepted start
pass  out  1  valid when done: err_cnt==0
err_cnt  out  16  mismatching words, saturates at 16'hFFFF
first_err_adr  out  ADR_W  word address of first mismatch, 0 if none

Behaviour:
- Reset: every output 0, FSM IDLE, pattern generator reseeded. Reset mid-run aborts immediately; controller FIFO contents are not the block's responsibility.
- FSM: IDLE -start-> WFILL; WFILL pushes BURST_LEN words, but only starts a burst when wr_remain_space>=BURST_LEN, one word per cycle, no gaps -> WCMD; WCMD holds until cmd_av=1, then pulses cmd_en one cycle with cmd_wr_rd=0, cmd_adr=start_adr+k*BURST_LEN -> WFILL for next k, or RCMD after the last burst (k reset to 0, generator reseeded); RCMD waits for cmd_av, pulses read cmd -> RDRAIN; RDRAIN asserts rd_en combinationally whenever rd_av=1 and words remain, compares rd_data with expected word that cycle -> RCMD for next burst or DONE; DONE sets done=1, busy=0, returns to IDLE-equivalent (accepts start).
- cmd_en never asserted while cmd_av=0; at most one cycle per command.
- Address arithmetic modulo 2^ADR_W (wrap-around allowed, not an error).
- Word address of word i = start_adr + global index. Patterns: mode 0 = replicated 8'hAA for even index, 8'h55 for odd; mode 1 = address zero-extended/truncated to DATA_W; mode 2 = 1 << (index mod DATA_W); mode 3 = 16-bit Galois LFSR, mask 16'hB400, seed 16'hACE1, steps once per word, replicated or truncated to DATA_W, reseeded at start of read phase.
- Mismatch: err_cnt increments (saturating); first_err_adr captured only on first mismatch of the run.
- start asserted on the same cycle DONE is entered: ignored; start in DONE/IDLE clears done, pass, err_cnt, first_err_adr.
- Latency: busy rises the cycle after an accepted start; first wr_en no earlier than that cycle.

Optional Feature:
SDRAM_BIST_LOOP_EN: when defined, after DONE the engine restarts automatically with the same mode and start_adr, keeping err_cnt/first_err_adr accumulated, and adds output loop_cnt (16-bit, saturating runs completed); start=0 with rst_n low is the only stop. Without it: single run, no loop_cnt port.

Decomposition:
- Package sdram_bist_pkg: state enum, mode enum, LFSR seed/mask constants, AA/55 byte constants.
- Sub-module sdram_bist_pattern: restart, step, mode, index, address inputs, expected/write word output; instantiated once, shared by write and read phases.

Test Plan:
- mode=1, start_adr=25'h100, ideal controller model -> 4 write cmds at 0x100,0x108,0x110,0x118, then 4 reads; done=1, pass=1, err_cnt=0.
- mode=1, model corrupts word at 0x105 -> err_cnt=1, first_err_adr=0x105, pass=0.
- mode=3 -> first two wr_data 16'hACE1, 16'hE270; readback matches, pass=1.
- cmd_av held 0 for 20 cycles in WCMD, wr_remain_space=4 -> no cmd_en, no wr_en beyond filled burst; resumes when released.
- start pulsed while busy; rst_n asserted during RDRAIN -> start ignored; on reset all outputs 0, busy=0, done=0.
- start_adr=25'h1FFFFFC, mode=0 -> second burst cmd_adr=25'h0000004 (wrap), pattern AAAA/5555 alternates, pass=1.
